// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer:
// branch funct3 encodings and the fence FSM state.
package pc_seq_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN,
        FENCE_WAIT
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decode/ALU, fetch and
// the PC sequencer.
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_out;
    logic [2:0]      funct3;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            zero;
    logic            less_than;
    logic            less_than_u;
    logic            fence;
    logic            fence_done;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            fence_busy;
    logic [XLEN-1:0] predecessor;
    logic [XLEN-1:0] successor;
    logic            misaligned;
    logic [XLEN-1:0] epc;

    modport master (
        output stall, imm, alu_out, funct3,
        output branch, jump, jalr,
        output zero, less_than, less_than_u,
        output fence, fence_done,
        input  pc, next_pc, fence_busy,
        input  predecessor, successor,
        input  misaligned, epc
    );

    modport slave (
        input  stall, imm, alu_out, funct3,
        input  branch, jump, jalr,
        input  zero, less_than, less_than_u,
        input  fence, fence_done,
        output pc, next_pc, fence_busy,
        output predecessor, successor,
        output misaligned, epc
    );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Conditional-branch resolver: funct3 plus ALU compare
// flags to a taken/not-taken bit.
module branch_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        unique case (1'b1)
            (i_funct3 == F3_BEQ):  o_cond = i_zero;
            (i_funct3 == F3_BNE):  o_cond = ~i_zero;
            (i_funct3 == F3_BLT):  o_cond = i_lt;
            (i_funct3 == F3_BGE):  o_cond = ~i_lt;
            (i_funct3 == F3_BLTU): o_cond = i_ltu;
            (i_funct3 == F3_BGEU): o_cond = ~i_ltu;
            default:               o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with branch/jump redirect,
// misaligned-target trap and FENCE drain state machine.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     PC_STEP      = 1,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = '0,
    parameter int unsigned     ALIGN_BITS   = 0,
    parameter bit              BR_BASE_NEXT = 1'b1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    pc_sequencer_if.slave bus
);

    // Zero-width mask when ALIGN_BITS is 0 disables the check.
    localparam logic [XLEN-1:0] ALIGN_MASK =
        (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    pc_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pred;
    logic [XLEN-1:0] r_succ;
    logic [XLEN-1:0] r_epc;
    logic            r_mis;
    logic            r_busy;

    logic            w_cond;
    logic            w_redirect;
    logic            w_is_jalr;
    logic            w_misalign;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_target;

    branch_cond u_cond (
        .i_funct3 (bus.funct3),
        .i_zero   (bus.zero),
        .i_lt     (bus.less_than),
        .i_ltu    (bus.less_than_u),
        .o_cond   (w_cond)
    );

    assign w_next_pc  = r_pc + XLEN'(PC_STEP);
    assign w_base     = BR_BASE_NEXT ? w_next_pc : r_pc;
    assign w_jalr_tgt = bus.alu_out & ~XLEN'(1);
    assign w_is_jalr  = bus.jump & bus.jalr;
    assign w_target   = w_is_jalr ? w_jalr_tgt
                                  : w_base + bus.imm;
    assign w_redirect = bus.jump | (bus.branch & w_cond);
    assign w_misalign = |(w_target & ALIGN_MASK);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_pred  <= '0;
            r_succ  <= '0;
            r_epc   <= '0;
            r_mis   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_mis <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (!bus.stall) begin
                        if (w_redirect && w_misalign) begin
                            r_pc  <= TRAP_VEC;
                            r_epc <= r_pc;
                            r_mis <= 1'b1;
                        end else if (w_redirect) begin
                            r_pc <= w_target;
                        end else if (bus.fence) begin
                            r_pred  <= r_pc;
                            r_succ  <= w_next_pc;
                            r_pc    <= w_next_pc;
                            r_state <= FENCE_WAIT;
                            r_busy  <= 1'b1;
                        end else begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                FENCE_WAIT: begin
                    if (bus.fence_done) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.next_pc     = w_next_pc;
    assign bus.fence_busy  = r_busy;
    assign bus.predecessor = r_pred;
    assign bus.successor   = r_succ;
    assign bus.misaligned  = r_mis;
    assign bus.epc         = r_epc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a default instance
// and a byte-addressed, alignment-checked instance.
module tb_pc_sequencer;

    typedef struct {
        int          sel;
        string       name;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] pred;
        logic [31:0] succ;
        logic [31:0] epc;
        logic        busy;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(32)) if0 ();
    pc_sequencer_if #(.XLEN(32)) if1 ();

    pc_sequencer dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if0.slave)
    );

    pc_sequencer #(
        .XLEN         (32),
        .PC_STEP      (4),
        .RESET_PC     (32'h200),
        .TRAP_VEC     (32'h40),
        .ALIGN_BITS   (2),
        .BR_BASE_NEXT (1'b0)
    ) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1.slave)
    );

    task automatic chk(input string n, input string f,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h want %h",
                     n, f, got, want);
        end
    endtask

    task automatic idle();
        if0.stall = 0; if0.imm = 0; if0.alu_out = 0;
        if0.funct3 = 0; if0.branch = 0; if0.jump = 0;
        if0.jalr = 0; if0.zero = 0; if0.less_than = 0;
        if0.less_than_u = 0; if0.fence = 0;
        if0.fence_done = 0;
        if1.stall = 0; if1.imm = 0; if1.alu_out = 0;
        if1.funct3 = 0; if1.branch = 0; if1.jump = 0;
        if1.jalr = 0; if1.zero = 0; if1.less_than = 0;
        if1.less_than_u = 0; if1.fence = 0;
        if1.fence_done = 0;
    endtask

    task automatic push(input int sel, input string n,
                        input logic [31:0] pc,
                        input logic [31:0] pred,
                        input logic [31:0] succ,
                        input logic [31:0] epc,
                        input logic busy, input logic mis);
        exp_t e;
        e.sel = sel; e.name = n; e.pc = pc;
        e.npc = pc + ((sel == 0) ? 32'd1 : 32'd4);
        e.pred = pred; e.succ = succ; e.epc = epc;
        e.busy = busy; e.mis = mis;
        sbq.push_back(e);
    endtask

    // Monitor: the sequencer has no valid strobe, so every
    // settled edge (clock or async reset) retires the
    // expectations queued for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.sel == 0) begin
                    chk(e.name, "pc", if0.pc, e.pc);
                    chk(e.name, "npc", if0.next_pc, e.npc);
                    chk(e.name, "pred", if0.predecessor, e.pred);
                    chk(e.name, "succ", if0.successor, e.succ);
                    chk(e.name, "epc", if0.epc, e.epc);
                    chk(e.name, "busy", 32'(if0.fence_busy), 32'(e.busy));
                    chk(e.name, "mis", 32'(if0.misaligned), 32'(e.mis));
                end else begin
                    chk(e.name, "pc", if1.pc, e.pc);
                    chk(e.name, "npc", if1.next_pc, e.npc);
                    chk(e.name, "pred", if1.predecessor, e.pred);
                    chk(e.name, "succ", if1.successor, e.succ);
                    chk(e.name, "epc", if1.epc, e.epc);
                    chk(e.name, "busy", 32'(if1.fence_busy), 32'(e.busy));
                    chk(e.name, "mis", 32'(if1.misaligned), 32'(e.mis));
                end
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        push(0, "rst", 0, 0, 0, 0, 0, 0);
        push(1, "rst_b", 32'h200, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1;
        push(0, "seq1", 1, 0, 0, 0, 0, 0);
        push(1, "seq1_b", 32'h204, 0, 0, 0, 0, 0);
        @(negedge clk); push(0, "seq2", 2, 0, 0, 0, 0, 0);
        @(negedge clk); push(0, "seq3", 3, 0, 0, 0, 0, 0);

        @(negedge clk); idle();
        if0.jump = 1; if0.jalr = 1; if0.alu_out = 32'h10;
        push(0, "jalr10", 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b101; if0.imm = 4;
        push(0, "bge_t", 32'h15, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.jump = 1; if0.jalr = 1; if0.alu_out = 32'h11;
        push(0, "jalr_odd", 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b101; if0.imm = 4;
        if0.less_than = 1;
        push(0, "bge_nt", 32'h11, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b000; if0.imm = 8;
        if0.zero = 1;
        push(0, "beq_t", 32'h1A, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b010; if0.imm = 8;
        if0.zero = 1; if0.less_than = 1; if0.less_than_u = 1;
        push(0, "f3_010", 32'h1B, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b110;
        if0.imm = 32'hFFFF_FFFE; if0.less_than_u = 1;
        push(0, "bltu_t", 32'h1A, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if0.branch = 1; if0.funct3 = 3'b001; if0.imm = 32'h10;
        push(0, "bne_t", 32'h2B, 0, 0, 0, 0, 0);

        @(negedge clk); idle();
        if0.jump = 1; if0.jalr = 1; if0.alu_out = 32'h20;
        push(0, "jalr20", 32'h20, 0, 0, 0, 0, 0);
        @(negedge clk); idle(); if0.fence = 1;
        push(0, "fence_in", 32'h21, 32'h20, 32'h21, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle();
            if0.fence = 1; if0.stall = (i == 1);
            if0.jump = (i == 2); if0.alu_out = 32'h80;
            push(0, "fwait", 32'h21, 32'h20, 32'h21, 0, 1, 0);
        end
        @(negedge clk); idle(); if0.fence_done = 1;
        push(0, "fexit", 32'h21, 32'h20, 32'h21, 0, 0, 0);
        @(negedge clk); idle();
        push(0, "fpost", 32'h22, 32'h20, 32'h21, 0, 0, 0);
        @(negedge clk); idle();
        if0.fence = 1; if0.fence_done = 1;
        push(0, "fmin_in", 32'h23, 32'h22, 32'h23, 0, 1, 0);
        @(negedge clk); idle(); if0.fence_done = 1;
        push(0, "fmin_out", 32'h23, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk); idle();
        if0.fence = 1; if0.jump = 1; if0.imm = 32'h10;
        push(0, "fence_redir", 32'h34, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk); idle(); if0.stall = 1; if0.fence = 1;
        push(0, "stall_fence", 32'h34, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk); idle(); if0.stall = 1; if0.jump = 1;
        push(0, "stall_jump", 32'h34, 32'h22, 32'h23, 0, 0, 0);

        @(negedge clk); idle();
        if0.jump = 1; if0.jalr = 1; if0.alu_out = 32'hFFFF_FFFF;
        push(0, "wrap0", 32'hFFFF_FFFE, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk); idle();
        push(0, "wrap1", 32'hFFFF_FFFF, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk);
        push(0, "wrap2", 32'h0, 32'h22, 32'h23, 0, 0, 0);

        @(negedge clk); idle();
        if0.jump = 1; if0.jalr = 1; if0.alu_out = 32'h5;
        push(0, "jalr5", 32'h4, 32'h22, 32'h23, 0, 0, 0);
        @(negedge clk); idle(); if0.fence = 1;
        push(0, "fence2", 32'h5, 32'h4, 32'h5, 0, 1, 0);
        @(negedge clk); idle();
        push(0, "arst", 0, 0, 0, 0, 0, 0);
        push(1, "arst_b", 32'h200, 0, 0, 0, 0, 0);
        rst_n = 0;
        @(negedge clk);
        push(0, "rst_hold", 0, 0, 0, 0, 0, 0);
        push(1, "rst_hold_b", 32'h200, 0, 0, 0, 0, 0);

        @(negedge clk); rst_n = 1;
        if1.jump = 1; if1.jalr = 1; if1.alu_out = 32'h100;
        push(0, "rel", 1, 0, 0, 0, 0, 0);
        push(1, "jalr100", 32'h100, 0, 0, 0, 0, 0);
        @(negedge clk); idle();
        if1.jump = 1; if1.jalr = 1; if1.alu_out = 32'h206;
        push(1, "trap_jalr", 32'h40, 0, 0, 32'h100, 0, 1);
        @(negedge clk); idle();
        push(1, "trap_clr", 32'h44, 0, 0, 32'h100, 0, 0);
        @(negedge clk); idle();
        if1.branch = 1; if1.funct3 = 3'b000; if1.zero = 1;
        if1.imm = 32'h10;
        push(1, "br_pcbase", 32'h54, 0, 0, 32'h100, 0, 0);
        @(negedge clk); idle(); if1.jump = 1; if1.imm = 2;
        push(1, "trap_jal", 32'h40, 0, 0, 32'h54, 0, 1);
        @(negedge clk); idle(); if1.stall = 1;
        push(1, "stall_mis", 32'h40, 0, 0, 32'h54, 0, 0);
        @(negedge clk); idle();
        if1.fence = 1; if1.jump = 1; if1.imm = 1;
        push(1, "trap_fence", 32'h40, 0, 0, 32'h40, 0, 1);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);

        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0",
                     sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC-V soft core: holds the architectural PC register, resolves all six conditional-branch types plus JAL/JALR redirects, and runs a FENCE drain state machine that captures predecessor/successor PCs and stalls fetch until the memory side reports completion. Target misalignment traps to a fixed vector with the faulting PC recorded. Sits between decode/ALU and instruction fetch; supersedes the previous combinational next-PC logic.

## Interface
- XLEN, 32, PC and data width
- PC_STEP, 1, sequential increment (1 = word-addressed, 4 = byte-addressed)
- RESET_PC, 0, PC value loaded at reset
- TRAP_VEC, 0, PC loaded on misaligned target
- ALIGN_BITS, 0, low target bits that must be zero (0 disables check)
- BR_BASE_NEXT, 1, branch/JAL base: 1 = next_pc + imm, 0 = pc + imm

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and FSM (RUN only)
- pc  out  XLEN  current PC register
- next_pc  out  XLEN  pc + PC_STEP, combinational
- imm  in  XLEN  sign-extended branch/JAL immediate
- alu_out  in  XLEN  JALR target from ALU
- funct3  in  3  branch condition select
- branch, jump, jalr  in  1 each  decoded control; jalr valid only with jump
- zero, less_than, less_than_u  in  1 each  ALU compare flags
- fence  in  1  current instruction is FENCE
- fence_done  in  1  memory system drained
- fence_busy  out  1  FSM in FENCE_WAIT
- predecessor, successor  out  XLEN  PC of FENCE and PC following it
- misaligned  out  1  one-cycle trap pulse
- epc  out  XLEN  PC of instruction whose target was misaligned

## Operation
- Branch condition (funct3): 000 zero, 001 ~zero, 100 less_than, 101 ~less_than, 110 less_than_u, 111 ~less_than_u, 010/011 never taken.
- redirect = jump | (branch & cond). Target: jalr ? {alu_out[XLEN-1:1],1'b0} : base + imm; base per BR_BASE_NEXT.
- All adds modulo 2^XLEN; wrap at all-ones silently.
- Priority per cycle: misaligned redirect > redirect > fence > sequential.
- Misaligned: redirect target with any of low ALIGN_BITS set -> pc <= TRAP_VEC, epc <= pc, misaligned <= 1 for one cycle.
- FSM states RUN, FENCE_WAIT.
  - RUN, stall=0, fence=1, no redirect: predecessor <= pc, successor <= next_pc, pc <= next_pc, go FENCE_WAIT.
  - FENCE_WAIT: pc held, fence_busy=1, stall and fence ignored; fence_done=1 -> RUN.
  - fence together with redirect: fence ignored, redirect taken.
- stall=1 in RUN: pc, epc, predecessor, successor, state all hold; misaligned deasserts.

## Timing
- Reset (async assert, sync release on clk): pc=RESET_PC, state RUN, fence_busy=0, predecessor=successor=epc=0, misaligned=0.
- PC update latency 1 cycle: inputs sampled on rising edge, new pc visible after it.
- fence_done sampled only in FENCE_WAIT; minimum FENCE_WAIT residence 1 cycle even if fence_done already high.
- fence_busy registered (= state==FENCE_WAIT).
- misaligned registered, high exactly the cycle pc==TRAP_VEC after trap.
- next_pc combinational from pc; no other comb. input-to-output paths.
- Reset mid-FENCE_WAIT returns to RUN at RESET_PC; captured PCs cleared.

## Structure
- Package pc_seq_pkg: funct3 constants (F3_BEQ..F3_BGEU), state enum pc_state_t {RUN, FENCE_WAIT}.
- Sub-module branch_cond: funct3 + three flags -> cond, purely combinational.
- Top holds PC register, target mux, alignment check, FSM and capture registers.

## Test plan
- Reset release, stall=0, no control: pc 0,1,2,3 on successive cycles; next_pc = pc+1.
- pc=0x10, branch=1, funct3=101, less_than=0, imm=4, BR_BASE_NEXT=1 -> pc=0x15; same with less_than=1 -> pc=0x11.
- pc=0x20, fence=1 -> predecessor=0x20, successor=0x21, pc=0x21, fence_busy=1; fence_done low 3 cycles pc holds 0x21; fence_done=1 -> fence_busy=0 next cycle, pc advances to 0x22.
- ALIGN_BITS=2, PC_STEP=4, pc=0x100, jump=1, jalr=1, alu_out=0x206 -> pc=TRAP_VEC, epc=0x100, misaligned high one cycle.
- pc=0xFFFFFFFF, PC_STEP=1 -> pc wraps to 0; stall=1 during fence=1 -> no capture, state stays RUN.
- Reset asserted during FENCE_WAIT -> immediately pc=RESET_PC, fence_busy=0, predecessor=successor=0.
